// File: rtl/ps2_receptor_fifo.sv
// PS/2 keyboard receiver: framing, E0/F0 prefix folding, event FIFO.
// Optional macro PS2_PARITY_CHECK_EN enables odd-parity enforcement.
module ps2_receptor_fifo #(
    parameter int SYNC_STAGES    = 2,
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            clkps,
    input  logic                            Rx,
    input  logic                            pop,
    output logic [7:0]                      codigo,
    output logic                            ext,
    output logic                            brk,
    output logic                            dato_valido,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] cuenta,
    output logic [7:0]                      ultimo,
    output logic                            error_trama,
    output logic                            desborde
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATOS, PARIDAD, PARADA} state_t;

    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_rx_sync;
    logic                   r_clk_prev;
    logic                   w_clk_s;
    logic                   w_rx_s;
    logic                   w_fall;

    state_t                 r_state;
    logic [2:0]             r_bitcnt;
    logic [7:0]             r_shift;
    logic                   r_par;
    logic [TW-1:0]          r_gap;
    logic                   r_good;
    logic [7:0]             r_code;
    logic                   r_err;
    logic                   r_ext_p;
    logic                   r_brk_p;
    logic [7:0]             r_ultimo;
    logic                   w_par_ok;
    logic                   w_frame_bad;
    logic                   w_push;

    logic [9:0]             r_mem [FIFO_DEPTH];
    logic [AW-1:0]          r_wr;
    logic [AW-1:0]          r_rd;
    logic [CW-1:0]          r_cnt;
    logic                   r_ovf;
    logic                   w_empty;
    logic                   w_full;
    logic                   w_wr;
    logic                   w_rd;
    logic [9:0]             w_head;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_sync <= '1;
            r_rx_sync  <= '1;
            r_clk_prev <= 1'b1;
        end else begin
            r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], clkps};
            r_rx_sync  <= {r_rx_sync[SYNC_STAGES-2:0], Rx};
            r_clk_prev <= w_clk_s;
        end
    end

    assign w_clk_s = r_clk_sync[SYNC_STAGES-1];
    assign w_rx_s  = r_rx_sync[SYNC_STAGES-1];
    assign w_fall  = r_clk_prev & ~w_clk_s;

`ifdef PS2_PARITY_CHECK_EN
    assign w_par_ok = ^{r_shift, r_par};
`else
    // parity bit is still captured so the frame timing is identical
    assign w_par_ok = r_par | ~r_par;
`endif

    assign w_frame_bad = w_fall && (r_state == PARADA) && !(w_rx_s && w_par_ok);
    assign w_push      = r_good && (r_code != 8'hE0) && (r_code != 8'hF0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_bitcnt <= '0;
            r_shift  <= '0;
            r_par    <= 1'b0;
            r_gap    <= '0;
            r_good   <= 1'b0;
            r_code   <= '0;
            r_err    <= 1'b0;
            r_ext_p  <= 1'b0;
            r_brk_p  <= 1'b0;
            r_ultimo <= '0;
        end else begin
            r_good <= 1'b0;
            r_err  <= 1'b0;
            if (w_fall || r_state == IDLE) r_gap <= '0;
            else                           r_gap <= r_gap + 1'b1;

            if (w_fall) begin
                case (r_state)
                    IDLE: begin
                        if (!w_rx_s) begin
                            r_state  <= DATOS;
                            r_bitcnt <= '0;
                        end
                    end
                    DATOS: begin
                        r_shift  <= {w_rx_s, r_shift[7:1]};
                        r_bitcnt <= r_bitcnt + 1'b1;
                        if (r_bitcnt == 3'd7) r_state <= PARIDAD;
                    end
                    PARIDAD: begin
                        r_par   <= w_rx_s;
                        r_state <= PARADA;
                    end
                    PARADA: begin
                        r_state <= IDLE;
                        if (w_frame_bad) begin
                            r_err <= 1'b1;
                        end else begin
                            r_good <= 1'b1;
                            r_code <= r_shift;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end else if (r_state != IDLE && r_gap == TW'(TIMEOUT_CYCLES - 1)) begin
                // timeout aborts the byte but keeps any pending prefix
                r_state <= IDLE;
                r_err   <= 1'b1;
            end

            if (r_good) begin
                if (r_code == 8'hE0) begin
                    r_ext_p <= 1'b1;
                end else if (r_code == 8'hF0) begin
                    r_brk_p <= 1'b1;
                end else begin
                    r_ext_p  <= 1'b0;
                    r_brk_p  <= 1'b0;
                    r_ultimo <= r_code;
                end
            end else if (w_frame_bad) begin
                r_ext_p <= 1'b0;
                r_brk_p <= 1'b0;
            end
        end
    end

    assign w_empty = (r_cnt == '0);
    assign w_full  = (r_cnt == CW'(FIFO_DEPTH));
    assign w_rd    = pop && !w_empty;
    assign w_wr    = w_push && (!w_full || w_rd);

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr] <= {r_ext_p, r_brk_p, r_code};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else begin
            if (w_wr) r_wr <= r_wr + 1'b1;
            if (w_rd) r_rd <= r_rd + 1'b1;
            if (w_wr && !w_rd)      r_cnt <= r_cnt + 1'b1;
            else if (!w_wr && w_rd) r_cnt <= r_cnt - 1'b1;
            if (w_push && !w_wr) r_ovf <= 1'b1;
        end
    end

    assign w_head      = r_mem[r_rd];
    assign dato_valido = !w_empty;
    assign codigo      = dato_valido ? w_head[7:0] : 8'h00;
    assign brk         = dato_valido & w_head[8];
    assign ext         = dato_valido & w_head[9];
    assign cuenta      = r_cnt;
    assign ultimo      = r_ultimo;
    assign error_trama = r_err;
    assign desborde    = r_ovf;

endmodule

// File: tb/tb_ps2_receptor_fifo.sv
// Scoreboard bench for ps2_receptor_fifo: directed PS/2 frames,
// monitor pops and compares FIFO entries against an expected queue.
module tb_ps2_receptor_fifo;

    localparam int DEPTH = 4;
    localparam int TMO   = 200;
    localparam int HP    = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic       clkps;
    logic       Rx;
    logic       pop;
    logic [7:0] codigo;
    logic       ext;
    logic       brk;
    logic       dato_valido;
    logic [2:0] cuenta;
    logic [7:0] ultimo;
    logic       error_trama;
    logic       desborde;

    logic [9:0] exp_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         err_cnt = 0;
    bit         auto_pop = 0;
    int         e0;

    ps2_receptor_fifo #(
        .SYNC_STAGES(2),
        .FIFO_DEPTH(DEPTH),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .clkps(clkps),
        .Rx(Rx),
        .pop(pop),
        .codigo(codigo),
        .ext(ext),
        .brk(brk),
        .dato_valido(dato_valido),
        .cuenta(cuenta),
        .ultimo(ultimo),
        .error_trama(error_trama),
        .desborde(desborde)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            Rx = bits[i];
            repeat (HP) @(negedge clk);
            clkps = 1'b0;
            repeat (HP) @(negedge clk);
            clkps = 1'b1;
        end
        Rx = 1'b1;
        repeat (2 * HP) @(negedge clk);
    endtask

    function automatic logic [10:0] frm(input logic [7:0] c, input bit bad_par, input bit bad_stop);
        logic p;
        p = ~(^c) ^ bad_par;
        return {~bad_stop, p, c, 1'b0};
    endfunction

    task automatic send(input logic [7:0] c);
        send_bits(frm(c, 0, 0), 11);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 200 && (exp_q.size() != 0 || dato_valido); i++)
            @(negedge clk);
        chk(name, exp_q.size(), 0);
    endtask

    // monitor: pops whenever enabled and an entry is presented
    initial begin
        logic [9:0] e;
        pop = 1'b0;
        forever begin
            @(negedge clk);
            pop = 1'b0;
            if (auto_pop && dato_valido) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL monitor: unexpected entry %h", {ext, brk, codigo});
                end else begin
                    e = exp_q.pop_front();
                    if ({ext, brk, codigo} !== e) begin
                        n_fail++;
                        $display("FAIL monitor: got %h expected %h", {ext, brk, codigo}, e);
                    end
                end
                pop = 1'b1;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (error_trama) err_cnt++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst   = 1'b1;
        clkps = 1'b1;
        Rx    = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_outs", {codigo, ext, brk, dato_valido, error_trama, desborde}, 0);
        chk("reset_cuenta", cuenta, 0);
        chk("reset_ultimo", ultimo, 0);

        // single make code
        exp_q.push_back({2'b00, 8'h1C});
        send(8'h1C);
        chk("1C_valid", dato_valido, 1);
        chk("1C_cuenta", cuenta, 1);
        chk("1C_ultimo", ultimo, 8'h1C);
        chk("1C_noerr", err_cnt, 0);
        auto_pop = 1;
        drain("1C_drain");

        // break and extended prefixes fold into one entry
        exp_q.push_back({2'b01, 8'h1C});
        send(8'hF0);
        send(8'h1C);
        drain("F0_1C_drain");
        auto_pop = 0;
        exp_q.push_back({2'b11, 8'h75});
        send(8'hE0);
        send(8'hF0);
        send(8'h75);
        chk("E0F075_cuenta", cuenta, 1);
        chk("E0F075_ultimo", ultimo, 8'h75);
        auto_pop = 1;
        drain("E0F075_drain");

        // bad parity
        e0 = err_cnt;
`ifdef PS2_PARITY_CHECK_EN
        send_bits(frm(8'h1C, 1, 0), 11);
        chk("par_err", err_cnt, e0 + 1);
        chk("par_cuenta", cuenta, 0);
`else
        exp_q.push_back({2'b00, 8'h1C});
        send_bits(frm(8'h1C, 1, 0), 11);
        drain("par_ignored_drain");
        chk("par_noerr", err_cnt, e0);
`endif

        // bad stop bit clears pending prefix
        e0 = err_cnt;
        exp_q.push_back({2'b00, 8'h1C});
        send(8'hF0);
        send_bits(frm(8'h22, 0, 1), 11);
        chk("stop_err", err_cnt, e0 + 1);
        send(8'h1C);
        drain("stop_clr_drain");

        // timeout after 5 data bits, then a clean frame
        e0 = err_cnt;
        send_bits(frm(8'h55, 0, 0), 6);
        repeat (TMO + 20) @(negedge clk);
        chk("tmo_err", err_cnt, e0 + 1);
        chk("tmo_empty", dato_valido, 0);
        exp_q.push_back({2'b00, 8'h32});
        send(8'h32);
        drain("tmo_32_drain");

        // timeout keeps pending prefix
        e0 = err_cnt;
        exp_q.push_back({2'b01, 8'h1C});
        send(8'hF0);
        send_bits(frm(8'h55, 0, 0), 6);
        repeat (TMO + 20) @(negedge clk);
        chk("tmo2_err", err_cnt, e0 + 1);
        send(8'h1C);
        drain("tmo_keep_drain");

        // overflow with depth 4
        auto_pop = 0;
        exp_q.push_back({2'b00, 8'h15});
        exp_q.push_back({2'b00, 8'h1D});
        exp_q.push_back({2'b00, 8'h24});
        exp_q.push_back({2'b00, 8'h2D});
        send(8'h15);
        send(8'h1D);
        send(8'h24);
        send(8'h2D);
        chk("full_no_ovf", desborde, 0);
        send(8'h2C);
        chk("ovf_cuenta", cuenta, 4);
        chk("ovf_flag", desborde, 1);
        auto_pop = 1;
        drain("ovf_drain");
        chk("ovf_sticky", desborde, 1);
        chk("ovf_empty_cnt", cuenta, 0);

        // reset in the middle of a frame
        auto_pop = 0;
        e0 = err_cnt;
        send_bits(frm(8'h66, 0, 0), 5);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (TMO + 50) @(negedge clk);
        chk("rst_noerr", err_cnt, e0);
        chk("rst_ovf_clr", desborde, 0);
        exp_q.push_back({2'b00, 8'h1C});
        send(8'h1C);
        chk("rst_cuenta", cuenta, 1);
        chk("rst_noerr2", err_cnt, e0);
        auto_pop = 1;
        drain("rst_drain");

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
